// File: rtl/lfsr_pkg.sv
// Shared constants and maximal-length tap masks for the LFSR generator.
package lfsr_pkg;

    localparam int unsigned LFSR_FIB = 0;
    localparam int unsigned LFSR_GAL = 1;

    // Bit k set means polynomial term x^(k+1); result is right-aligned in 32 bits.
    function automatic logic [31:0] max_taps(input int unsigned width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_period_counter.sv
// Measures steps until the LFSR returns to its seed; flags a missing return
// after 2^WIDTH-1 steps.
module lfsr_period_counter
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter logic [31:0] RESET_SEED = 32'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_next_state,
    output logic [WIDTH-1:0] o_period,
    output logic             o_period_valid,
    output logic             o_no_repeat
);

    localparam logic [WIDTH-1:0] SEED_RST = WIDTH'(RESET_SEED);
    localparam logic [WIDTH-1:0] FULL     = '1;

    logic [WIDTH-1:0] r_seed_q;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic             r_period_valid;
    logic             r_no_repeat;

    logic [WIDTH-1:0] w_count_inc;
    logic             w_match;
    logic             w_done;

    assign w_count_inc = r_count + WIDTH'(1);
    assign w_match     = (i_next_state == r_seed_q);
    assign w_done      = r_period_valid | r_no_repeat;

    // Count freezes once a verdict is reached, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seed_q       <= SEED_RST;
            r_count        <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_no_repeat    <= 1'b0;
        end else if (i_load) begin
            r_seed_q       <= i_seed;
            r_count        <= '0;
            r_period_valid <= 1'b0;
            r_no_repeat    <= 1'b0;
        end else if (i_step && !w_done) begin
            r_count <= w_count_inc;
            if (w_match) begin
                r_period       <= w_count_inc;
                r_period_valid <= 1'b1;
            end else if (w_count_inc == FULL) begin
                r_no_repeat    <= 1'b1;
            end
        end
    end

    assign o_period       = r_period;
    assign o_period_valid = r_period_valid;
    assign o_no_repeat    = r_no_repeat;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load and lock-up decode.
// Period checker is built only when LFSR_PERIOD_CHECK_EN is defined.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter logic [31:0] TAPS       = 32'd0,
    parameter int unsigned GALOIS     = 0,
    parameter logic [31:0] RESET_SEED = 32'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    output logic [WIDTH-1:0] state,
    output logic             lockup,
    output logic             period_valid,
    output logic [WIDTH-1:0] period,
    output logic             no_repeat
);

    localparam logic [WIDTH-1:0] MASK     = (TAPS == 32'd0) ? WIDTH'(max_taps(WIDTH))
                                                            : WIDTH'(TAPS);
    localparam logic [WIDTH-1:0] SEED_RST = WIDTH'(RESET_SEED);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next_state;
    logic             w_lockup;

    if (GALOIS == LFSR_GAL) begin : g_galois
        assign w_next_state = (r_state >> 1) ^ ({WIDTH{r_state[0]}} & MASK);
    end else begin : g_fibonacci
        assign w_next_state = {r_state[WIDTH-2:0], ^(r_state & MASK)};
    end

    // Zero is a fixed point of both forms, so no special-case hold is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED_RST;
        end else if (load) begin
            r_state <= seed;
        end else if (en) begin
            r_state <= w_next_state;
        end
    end

    assign w_lockup = (r_state == '0);
    assign state    = r_state;
    assign lockup   = w_lockup;

`ifdef LFSR_PERIOD_CHECK_EN
    logic w_step;
    assign w_step = en && !w_lockup;

    lfsr_period_counter #(
        .WIDTH      (WIDTH),
        .RESET_SEED (RESET_SEED)
    ) u_period_counter (
        .clk            (clk),
        .reset          (reset),
        .i_load         (load),
        .i_seed         (seed),
        .i_step         (w_step),
        .i_next_state   (w_next_state),
        .o_period       (period),
        .o_period_valid (period_valid),
        .o_no_repeat    (no_repeat)
    );
`else
    assign period       = '0;
    assign period_valid = 1'b0;
    assign no_repeat    = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: four configurations, directed vectors.
// Checker expectations collapse to zero when LFSR_PERIOD_CHECK_EN is undefined.
module tb_lfsr_gen;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst, ld, en;
    logic [7:0] sd [4];

    logic [3:0] st0, st2, st3;
    logic [7:0] st1;
    logic [3:0] per0, per2, per3;
    logic [7:0] per1;
    logic [3:0] lk, pv, nr;

    lfsr_gen #(.WIDTH(4)) u_fib4 (
        .clk(clk), .reset(rst[0]), .load(ld[0]), .seed(sd[0][3:0]), .en(en[0]),
        .state(st0), .lockup(lk[0]), .period_valid(pv[0]), .period(per0), .no_repeat(nr[0]));
    lfsr_gen #(.WIDTH(8), .GALOIS(1)) u_gal8 (
        .clk(clk), .reset(rst[1]), .load(ld[1]), .seed(sd[1]), .en(en[1]),
        .state(st1), .lockup(lk[1]), .period_valid(pv[1]), .period(per1), .no_repeat(nr[1]));
    lfsr_gen #(.WIDTH(4), .TAPS(32'hF)) u_nm4 (
        .clk(clk), .reset(rst[2]), .load(ld[2]), .seed(sd[2][3:0]), .en(en[2]),
        .state(st2), .lockup(lk[2]), .period_valid(pv[2]), .period(per2), .no_repeat(nr[2]));
    lfsr_gen #(.WIDTH(4), .TAPS(32'h1)) u_nr4 (
        .clk(clk), .reset(rst[3]), .load(ld[3]), .seed(sd[3][3:0]), .en(en[3]),
        .state(st3), .lockup(lk[3]), .period_valid(pv[3]), .period(per3), .no_repeat(nr[3]));

    typedef struct {
        int unsigned due;
        int          dut;
        bit          cs;
        logic [7:0]  st;
        bit          lk;
        bit          pv;
        logic [7:0]  per;
        bit          nr;
        string       nm;
    } sb_t;

    sb_t         sb_q[$];
    int unsigned cyc_cnt = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Drive one cycle on DUT d (others idle) and queue what must be seen after the edge.
    task automatic cyc(input int d, input bit r, input bit l, input logic [7:0] s,
                       input bit e, input bit cs, input logic [7:0] est,
                       input bit epv, input logic [7:0] eper, input bit enr,
                       input string nm);
        sb_t x;
        rst = '0; ld = '0; en = '0;
        rst[d] = r; ld[d] = l; en[d] = e; sd[d] = s;
`ifndef LFSR_PERIOD_CHECK_EN
        epv = 1'b0; eper = '0; enr = 1'b0;
`endif
        x.due = cyc_cnt + 1; x.dut = d; x.cs = cs; x.st = est;
        x.lk = cs && (est == 8'h00);
        x.pv = epv; x.per = eper; x.nr = enr; x.nm = nm;
        sb_q.push_back(x);
        @(posedge clk); #1;
    endtask

    // Monitor: every due expectation is compared against the outputs mid-cycle.
    always @(negedge clk) begin : monitor
        sb_t        x;
        logic [7:0] a_st, a_per;
        logic       a_lk, a_pv, a_nr;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc_cnt) begin
            x = sb_q.pop_front();
            case (x.dut)
                0:       begin a_st = {4'h0, st0}; a_per = {4'h0, per0}; end
                1:       begin a_st = st1;         a_per = per1;         end
                2:       begin a_st = {4'h0, st2}; a_per = {4'h0, per2}; end
                default: begin a_st = {4'h0, st3}; a_per = {4'h0, per3}; end
            endcase
            a_lk = lk[x.dut]; a_pv = pv[x.dut]; a_nr = nr[x.dut];
            n_cmp++;
            if ((x.due != cyc_cnt) || (x.cs && a_st !== x.st) || a_lk !== x.lk ||
                a_pv !== x.pv || a_per !== x.per || a_nr !== x.nr) begin
                n_bad++;
                $display("FAIL %s dut%0d cyc%0d: got state=%h lockup=%b pv=%b period=%h no_repeat=%b; need state=%h(chk=%b) lockup=%b pv=%b period=%h no_repeat=%b",
                         x.nm, x.dut, cyc_cnt, a_st, a_lk, a_pv, a_per, a_nr,
                         x.st, x.cs, x.lk, x.pv, x.per, x.nr);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] fib [15];
        logic [7:0] gal [6];
        logic [7:0] nm  [5];
        int         steps;
        int         iters;
        bit         e;

        fib = '{8'h1, 8'h2, 8'h4, 8'h9, 8'h3, 8'h6, 8'hD, 8'hA,
                8'h5, 8'hB, 8'h7, 8'hF, 8'hE, 8'hC, 8'h8};
        gal = '{8'hA5, 8'hEA, 8'h75, 8'h82, 8'h41, 8'h98};
        nm  = '{8'h1, 8'h3, 8'h6, 8'hC, 8'h8};

        rst = '0; ld = '0; en = '0;
        for (int i = 0; i < 4; i++) sd[i] = '0;
        @(posedge clk); #1;

        // Reset state of every configuration
        for (int d = 0; d < 4; d++)
            cyc(d, 1, 0, 8'h0, 1, 1, 8'h01, 0, 8'h0, 0, "reset_state");

        // Fibonacci WIDTH=4: full period from seed 1
        cyc(0, 0, 1, 8'h1, 0, 1, 8'h1, 0, 8'h0, 0, "fib_load1");
        for (int k = 1; k <= 17; k++)
            cyc(0, 0, 0, 8'h0, 1, 1, fib[k % 15], (k >= 15), (k >= 15) ? 8'd15 : 8'd0, 0,
                "fib_period");
        for (int k = 0; k < 3; k++)
            cyc(0, 0, 0, 8'h0, 0, 1, fib[2], 1, 8'd15, 0, "fib_hold");

        // Zero seed: locked up, checker frozen, period retained
        cyc(0, 0, 1, 8'h0, 0, 1, 8'h0, 0, 8'd15, 0, "zero_load");
        for (int k = 0; k < 20; k++)
            cyc(0, 0, 0, 8'h0, 1, 1, 8'h0, 0, 8'd15, 0, "lockup_hold");

        // Reload mid-run with en high in the load cycle: count restarts
        cyc(0, 0, 1, 8'h1, 0, 1, 8'h1, 0, 8'd15, 0, "reload1");
        for (int k = 1; k <= 7; k++)
            cyc(0, 0, 0, 8'h0, 1, 1, fib[k], 0, 8'd15, 0, "pre_reload");
        cyc(0, 0, 1, 8'h3, 1, 1, 8'h3, 0, 8'd15, 0, "load_with_en");
        for (int j = 1; j <= 18; j++)
            cyc(0, 0, 0, 8'h0, 1, 1, fib[(4 + j) % 15], (j >= 15), 8'd15, 0, "seed3_period");

        // Reset overrides load and en mid-run
        cyc(0, 1, 1, 8'h7, 1, 1, 8'h1, 0, 8'd0, 0, "midrun_reset");
        cyc(0, 0, 0, 8'h0, 1, 1, 8'h2, 0, 8'd0, 0, "post_reset_step");

        // Galois WIDTH=8 with randomly gated en
        cyc(1, 0, 1, 8'hA5, 0, 1, 8'hA5, 0, 8'd0, 0, "gal_load");
        steps = 0;
        iters = 0;
        while (steps < 255 && iters < 4000) begin
            e = 1'($urandom_range(0, 1));
            if (e) steps++;
            iters++;
            if (steps <= 5)
                cyc(1, 0, 0, 8'h0, e, 1, gal[steps], 0, 8'd0, 0, "gal_early");
            else if (steps == 255)
                cyc(1, 0, 0, 8'h0, e, 1, 8'hA5, 1, 8'd255, 0, "gal_period");
            else
                cyc(1, 0, 0, 8'h0, e, 0, 8'h0, 0, 8'd0, 0, "gal_run");
        end
        n_cmp++;
        if (steps != 255) begin
            n_bad++;
            $display("FAIL gal_budget: enabled steps %0d, need 255", steps);
        end
        cyc(1, 0, 0, 8'h0, 1, 1, 8'hEA, 1, 8'd255, 0, "gal_sticky");
        cyc(1, 0, 0, 8'h0, 1, 1, 8'h75, 1, 8'd255, 0, "gal_sticky");

        // Non-maximal taps 4'hF: period 5
        cyc(2, 0, 1, 8'h1, 0, 1, 8'h1, 0, 8'd0, 0, "nm_load");
        for (int k = 1; k <= 7; k++)
            cyc(2, 0, 0, 8'h0, 1, 1, nm[k % 5], (k >= 5), (k >= 5) ? 8'd5 : 8'd0, 0, "nm_period");

        // Taps 4'h1 never returns to seed 3: no_repeat after 15 steps
        cyc(3, 0, 1, 8'h3, 0, 1, 8'h3, 0, 8'd0, 0, "nr_load");
        for (int k = 1; k <= 17; k++)
            cyc(3, 0, 0, 8'h0, 1, 1, (k == 1) ? 8'h7 : 8'hF, 0, 8'd0, (k >= 15), "no_repeat");

        rst = '0; ld = '0; en = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, need 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
